shift_load_sequencer: RTL
=========================

Name: shift_load_sequencer

Overview:
- Controller that serially loads a W-bit word into the team's right-shift register, which has ports Reset, Ck, Shift, SI and Q[W-1:0].
- Drives the register's Shift and SI over W consecutive cycles, then reads back Q and compares it against the requested word.
- Reports completion with a Done pulse and a Match flag; sits between a parallel requester and the shift-register datapath.

Parameters:
W, 4, word width; must equal the shift register width.

Ports:
Ck  input  1  clock; all state changes on the rising edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  request to load DataIn; sampled only in IDLE.
DataIn  input  W  word to load; captured in the cycle Start is accepted.
Abort  input  1  cancels a load in progress.
Q  input  W  parallel output of the shift register, used for readback.
Shift  output  1  shift enable to the shift register.
SI  output  1  serial data to the shift register.
Busy  output  1  high in every state except IDLE.
Done  output  1  one-cycle pulse marking load completion.
Match  output  1  readback result; valid while Done=1, held until the next accept.

Behaviour:
- Clocking and reset:
  - One clock (Ck). Reset is synchronous and active-high.
  - Reset forces state=IDLE, Shift=0, SI=0, Busy=0, Done=0, Match=0, count=0, data register=0.
- Output timing: Shift, SI, Done and Match are registered, so no combinational path runs from any input to them.
- Register contract: the shift register moves right and SI enters Q[W-1]. The word is therefore sent LSB first, and after W shifts Q equals DataIn.
- States and transitions:
  - IDLE: Start=1 at an edge latches DataIn into dreg, sets count=0 and goes to SHIFT.
  - SHIFT: Shift=1 and SI=dreg[count]. At each edge count increments. At the edge where count=W-1, go to CHECK.
  - CHECK: Shift=0, SI=0. Q is stable here. At the edge, Match is set to (Q==dreg) and the state goes to DONE.
  - DONE: Done=1 for exactly one cycle, then IDLE.
- Latency: Start accepted at edge n gives:
  - Shift=1 during cycles n+1 through n+W;
  - CHECK during cycle n+W+1;
  - Done=1 during cycle n+W+2.
  - Total is W+2 cycles from accept to Done.
- Start handling:
  - Start is ignored while Busy=1; there is no queueing.
  - Start held high across DONE is re-accepted only once IDLE is reached, so back-to-back loads are separated by one IDLE cycle.
- Abort:
  - Abort=1 in SHIFT or CHECK returns the controller to IDLE at that edge, with Shift=0, SI=0, no Done pulse, and Match unchanged.
  - Abort in IDLE or DONE has no effect.
  - Abort has priority over count completion.
- Simultaneous inputs:
  - Reset has priority over everything.
  - Start together with Abort in IDLE is accepted.
- Reset in mid-operation: the controller returns to IDLE in the next cycle. The shift register keeps its partial contents, because the controller does not clear it.
- Counter: width is clog2(W), minimum 1. It never wraps during normal operation, because the state exits at W-1.

Decomposition:
- Shared package shift_ctrl_pkg holds:
  - the state encoding constants: IDLE=2'd0, SHIFT=2'd1, CHECK=2'd2, DONE=2'd3;
  - a clog2 helper function.
- Single module; no sub-module is needed.
- The bench instantiates this controller together with the existing shift register and connects Shift, SI and Q.

Test Plan:
1. Reset held for 3 cycles, then Start with DataIn=4'b1011: SI sequence 1,1,0,1 during Shift=1 for 4 cycles; Q=1011 in CHECK; Done pulse at cycle n+6 with Match=1.
2. Two back-to-back loads, 4'b0110 then 4'b1001, with Start held high: second accept comes one cycle after the first Done; both give Match=1 and Q ends at 1001.
3. Abort asserted in the 2nd SHIFT cycle of a load of 4'b1111: Shift drops at the next edge, no Done, Busy=0; a following Start with 4'b0001 completes with Match=1.
4. Bench forces Q to 4'b0000 in CHECK while loading 4'b1010: Done=1 with Match=0.
5. Start pulsed while Busy=1 with a different DataIn: it is ignored, and the original word completes with Match=1.
6. Reset asserted in the 3rd SHIFT cycle: all outputs are 0 in the next cycle and state is IDLE; a following Start with 4'b0101 gives Match=1.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift-register load sequencer.
// State encoding and a width helper.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Counter width helper; never returns less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/shift_reg.sv
// Right-shift register: SI enters Q[W-1], contents move toward Q[0].
// Loaded serially by shift_load_sequencer.
module shift_reg #(
  parameter int W = 4
) (
  input  logic         Ck,
  input  logic         Reset,
  input  logic         Shift,
  input  logic         SI,
  output logic [W-1:0] Q
);

  always_ff @(posedge Ck) begin
    if (Reset) begin
      Q <= '0;
    end else if (Shift) begin
      if (W > 1) Q <= {SI, Q[W-1:1]};
      else       Q <= {W{SI}};
    end
  end

endmodule

// File: rtl/shift_load_sequencer.sv
// Serially loads a word LSB-first into the right-shift register,
// then reads Q back and reports Done with a Match flag.
module shift_load_sequencer
  import shift_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         Ck,
  input  logic         Reset,
  input  logic         Start,
  input  logic [W-1:0] DataIn,
  input  logic         Abort,
  input  logic [W-1:0] Q,
  output logic         Shift,
  output logic         SI,
  output logic         Busy,
  output logic         Done,
  output logic         Match
);

  localparam int CW = clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [W-1:0]  dreg;

  assign count_nxt = count + 1'b1;

  // Outputs are computed for the state being entered, so they
  // line up with that state's cycle while staying registered.
  always_ff @(posedge Ck) begin
    if (Reset) begin
      state <= IDLE;
      count <= '0;
      dreg  <= '0;
      Shift <= 1'b0;
      SI    <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Match <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            dreg  <= DataIn;
            count <= '0;
            state <= SHIFT;
            Shift <= 1'b1;
            SI    <= DataIn[0];
            Busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (Abort) begin
            state <= IDLE;
            count <= '0;
            Shift <= 1'b0;
            SI    <= 1'b0;
            Busy  <= 1'b0;
          end else if (count == LAST) begin
            state <= CHECK;
            count <= '0;
            Shift <= 1'b0;
            SI    <= 1'b0;
          end else begin
            count <= count_nxt;
            SI    <= dreg[count_nxt];
          end
        end
        CHECK: begin
          if (Abort) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            Match <= (Q == dreg);
            Done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          Shift <= 1'b0;
          SI    <= 1'b0;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
